fetch_sequencer: RTL

- Sequences the instruction memory: owns the program counter, drives the memory address and registers each fetched 20-bit word into a one-entry output slot for the decode stage.
- Handles the decode-stage stall (valid/ready), branch/jump redirect with flush, and halt detection.
- Sits between instruction_memory (combinational read) and the IF/ID boundary of the pipeline.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and defaults for the fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fetch_state_t;
    localparam logic [19:0] HALT_INSTR_DEFAULT = 20'hFFFFF;
    localparam int MEM_SIZE_DEFAULT = 256;
    localparam int WRAP_PC = 0;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, one-entry IF/ID slot, redirect flush and halt drain
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]    imem_instruction,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_instruction,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    input  logic                     if_ready,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     busy,
    output logic                     halted
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WRAP = ADDRESS_WIDTH'(WRAP_PC);
    fetch_state_t r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt, r_pc, w_pc_nxt, w_seq_pc;
    logic [DATA_WIDTH-1:0] r_instr, w_instr_nxt;
    logic r_valid, w_valid_nxt, w_writable;
    assign w_seq_pc = (r_fetch_pc == LAST_PC) ? WRAP : r_fetch_pc + 1'b1;
    assign w_writable = !r_valid || if_ready;
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_pc_nxt = r_pc;
        case (r_state)
            IDLE, HALTED: begin
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = RUN;
                    w_fetch_pc_nxt = RESET_PC;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    w_valid_nxt = 1'b0;
                    w_fetch_pc_nxt = redirect_pc;
                end else if (w_writable) begin
                    w_instr_nxt = imem_instruction;
                    w_pc_nxt = r_fetch_pc;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = (imem_instruction == HALT_INSTR) ? DRAIN : RUN;
                    w_fetch_pc_nxt = (imem_instruction == HALT_INSTR) ? r_fetch_pc : w_seq_pc;
                end
            end
            DRAIN: begin
                // a redirect here means the halt was on a mispredicted path
                if (redirect_valid) begin
                    w_valid_nxt = 1'b0;
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt = RUN;
                end else if (if_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = HALTED;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_pc <= w_pc_nxt;
        end
    end
    assign imem_address = r_fetch_pc;
    assign if_valid = r_valid;
    assign if_instruction = r_instr;
    assign if_pc = r_pc;
    assign busy = (r_state == RUN) || (r_state == DRAIN);
    assign halted = (r_state == HALTED);
endmodule
